// File: rtl/pe_context_seq_pkg.sv
// Shared types and constants for the per-PE context sequencer.
// Optional stall input is enabled with `define PE_CTX_STALL_EN.
package pe_context_seq_pkg;

  localparam int unsigned PE_INST_W = 48;
  localparam int unsigned PE_DEPTH  = 16;
  localparam int unsigned PE_ADDR_W = 4;
  localparam int unsigned PE_ITER_W = 16;

  localparam logic [PE_INST_W-1:0] CTX_NOP = '0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/pe_context_seq_if.sv
// Config/launch/instruction bundle between a controller and the context sequencer.
// Carries the stall line only when PE_CTX_STALL_EN is defined.
interface pe_context_seq_if #(
  parameter int unsigned INST_W = 48,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned ITER_W = 16
);
  logic              cfg_valid;
  logic              cfg_ready;
  logic [ADDR_W-1:0] cfg_addr;
  logic [INST_W-1:0] cfg_data;
  logic              start;
  logic [ADDR_W:0]   len;
  logic [ITER_W-1:0] iter_cnt;
  logic              abort;
  logic [INST_W-1:0] inst;
  logic              busy;
  logic              done;
`ifdef PE_CTX_STALL_EN
  logic              stall;
`endif

  modport master (
    output cfg_valid, cfg_addr, cfg_data, start, len, iter_cnt, abort,
`ifdef PE_CTX_STALL_EN
    output stall,
`endif
    input  cfg_ready, inst, busy, done
  );

  modport slave (
    input  cfg_valid, cfg_addr, cfg_data, start, len, iter_cnt, abort,
`ifdef PE_CTX_STALL_EN
    input  stall,
`endif
    output cfg_ready, inst, busy, done
  );

endinterface

// File: rtl/pe_context_seq_mem.sv
// Context slot array: one write port, one combinational read port with
// write-through bypass so a same-edge write is visible to the reader.
module pe_ctx_mem #(
  parameter int unsigned INST_W = 48,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [INST_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [INST_W-1:0] rd_data
);

  logic [INST_W-1:0] mem_q [DEPTH];
  logic [INST_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[wr_addr] = wr_data;
  end

  always_comb begin
    rd_data = mem_q[rd_addr];
    if (we && (wr_addr == rd_addr)) rd_data = wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/pe_context_seq.sv
// Per-PE context sequencer: replays slots 0..len-1 for iter_cnt iterations.
// Define PE_CTX_STALL_EN to add a stall input that freezes a run in place.
module pe_context_seq
  import pe_context_seq_pkg::*;
#(
  parameter int unsigned INST_W = PE_INST_W,
  parameter int unsigned DEPTH  = PE_DEPTH,
  parameter int unsigned ADDR_W = PE_ADDR_W,
  parameter int unsigned ITER_W = PE_ITER_W
) (
  input  logic            clk,
  input  logic            rst,
  pe_context_seq_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_q, cur_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ITER_W-1:0] iter_left_q, iter_left_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;

  logic              wr_en;
  logic [ADDR_W:0]   next_idx;
  logic              more_ctx;
  logic [ADDR_W-1:0] rd_addr;
  logic [INST_W-1:0] rd_data;
  logic              launch_ok;
  logic              stall_w;

`ifdef PE_CTX_STALL_EN
  assign stall_w = bus.stall;
`else
  assign stall_w = 1'b0;
`endif

  assign wr_en     = bus.cfg_valid && (state_q == IDLE);
  assign next_idx  = {1'b0, cur_q} + 1'b1;
  assign more_ctx  = next_idx < len_q;
  // Single read port: next slot while mid-iteration, otherwise slot 0 (launch or wrap).
  assign rd_addr   = ((state_q == RUN) && more_ctx) ? next_idx[ADDR_W-1:0] : '0;
  assign launch_ok = (bus.len != '0) && (bus.len <= (ADDR_W+1)'(DEPTH)) && (bus.iter_cnt != '0);

  pe_ctx_mem #(
    .INST_W (INST_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_en),
    .wr_addr (bus.cfg_addr),
    .wr_data (bus.cfg_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    len_d       = len_q;
    iter_left_d = iter_left_q;
    inst_d      = inst_q;
    done_d      = 1'b0;
    unique case (state_q)
      IDLE: begin
        inst_d = CTX_NOP;
        if (bus.start) begin
          if (launch_ok) begin
            state_d     = RUN;
            cur_d       = '0;
            len_d       = bus.len;
            iter_left_d = bus.iter_cnt;
            inst_d      = rd_data;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
          inst_d  = CTX_NOP;
        end else if (!stall_w) begin
          if (more_ctx) begin
            cur_d  = next_idx[ADDR_W-1:0];
            inst_d = rd_data;
          end else if (iter_left_q > ITER_W'(1)) begin
            iter_left_d = iter_left_q - 1'b1;
            cur_d       = '0;
            inst_d      = rd_data;
          end else begin
            state_d = IDLE;
            inst_d  = CTX_NOP;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cur_q       <= '0;
      len_q       <= '0;
      iter_left_q <= '0;
      inst_q      <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      len_q       <= len_d;
      iter_left_q <= iter_left_d;
      inst_q      <= inst_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.cfg_ready = (state_q == IDLE);
  assign bus.inst      = inst_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_pe_context_seq.sv
// Self-checking bench for pe_context_seq against a slot-array reference model.
module tb_pe_context_seq;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [47:0] model_mem [16];

  pe_context_seq_if #(.INST_W(48), .ADDR_W(4), .ITER_W(16)) bus ();

  pe_context_seq #(
    .INST_W (48),
    .DEPTH  (16),
    .ADDR_W (4),
    .ITER_W (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_slot(input int addr, input logic [47:0] data);
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = 4'(addr);
    bus.cfg_data  = data;
    tick();
    bus.cfg_valid = 1'b0;
    model_mem[addr] = data;
  endtask

  task automatic launch(input int len, input int iter);
    bus.start    = 1'b1;
    bus.len      = 5'(len);
    bus.iter_cnt = 16'(iter);
    tick();
    bus.start    = 1'b0;
    bus.len      = 5'($urandom_range(0, 31));
    bus.iter_cnt = 16'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.inst !== 48'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: inst=%h busy=%b done=%b, want 0/0/0", bus.inst, bus.busy, bus.done);
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: cfg_ready=%b, want 1", bus.cfg_ready);
    end
    for (int i = 0; i < 4; i++) load_slot(i, {16'($urandom), $urandom} | 48'h1);
    launch(4, 4);
    tick();
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_prerun_busy: busy=%b, want 1", bus.busy);
    end
    #2 rst = 1'b0;
    #1;
    n_checks++;
    if (bus.inst !== 48'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midrun: inst=%h busy=%b done=%b, want 0/0/0", bus.inst, bus.busy, bus.done);
    end
    for (int i = 0; i < 16; i++) model_mem[i] = 48'h0;
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (bus.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_midrun_ready: cfg_ready=%b, want 1", bus.cfg_ready);
    end
    launch(16, 1);
    for (int k = 0; k < 16; k++) begin
      n_checks++;
      if (bus.inst !== model_mem[k] || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_slot_clear[%0d]: inst=%h busy=%b, want %h/1", k, bus.inst, bus.busy, model_mem[k]);
      end
      tick();
    end
    n_checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_run_done: done=%b busy=%b, want 1/0", bus.done, bus.busy);
    end
    tick();
  endtask

  task automatic test_basic();
    load_slot(0, 48'h1);
    load_slot(1, 48'h2);
    load_slot(2, 48'h3);
    launch(3, 2);
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (bus.inst !== model_mem[k % 3] || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_seq[%0d]: inst=%h busy=%b done=%b, want %h/1/0", k, bus.inst, bus.busy, bus.done, model_mem[k % 3]);
      end
      tick();
    end
    n_checks++;
    if (bus.inst !== 48'h0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_end: inst=%h done=%b busy=%b, want 0/1/0", bus.inst, bus.done, bus.busy);
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b0 || bus.cfg_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_done_pulse: done=%b cfg_ready=%b, want 0/1", bus.done, bus.cfg_ready);
    end
  endtask

  task automatic test_invalid_start();
    int lens [3] = '{0, 17, 5};
    int iters [3] = '{2, 2, 0};
    for (int t = 0; t < 3; t++) begin
      launch(lens[t], iters[t]);
      n_checks++;
      if (bus.done !== 1'b1 || bus.inst !== 48'h0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL invalid_start[%0d]: done=%b inst=%h busy=%b, want 1/0/0", t, bus.done, bus.inst, bus.busy);
      end
      tick();
      n_checks++;
      if (bus.done !== 1'b0 || bus.inst !== 48'h0 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL invalid_after[%0d]: done=%b inst=%h busy=%b, want 0/0/0", t, bus.done, bus.inst, bus.busy);
      end
    end
  endtask

  task automatic test_bypass();
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = 4'd0;
    bus.cfg_data  = 48'hABC;
    model_mem[0]  = 48'hABC;
    launch(1, 3);
    bus.cfg_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (bus.inst !== 48'hABC || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bypass_seq[%0d]: inst=%h busy=%b, want abc/1", k, bus.inst, bus.busy);
      end
      tick();
    end
    n_checks++;
    if (bus.inst !== 48'h0 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL bypass_end: inst=%h done=%b, want 0/1", bus.inst, bus.done);
    end
    tick();
  endtask

  task automatic test_abort();
    for (int i = 0; i < 6; i++) load_slot(i, {16'($urandom), $urandom});
    launch(4, 1);
    tick();
    n_checks++;
    if (bus.inst !== model_mem[1] || bus.cfg_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_second_ctx: inst=%h cfg_ready=%b, want %h/0", bus.inst, bus.cfg_ready, model_mem[1]);
    end
    bus.abort     = 1'b1;
    bus.cfg_valid = 1'b1;
    bus.cfg_addr  = 4'd5;
    bus.cfg_data  = ~model_mem[5];
    tick();
    bus.abort     = 1'b0;
    bus.cfg_valid = 1'b0;
    n_checks++;
    if (bus.inst !== 48'h0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_stop: inst=%h busy=%b done=%b, want 0/0/0", bus.inst, bus.busy, bus.done);
    end
    tick();
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: done=%b, want 0", bus.done);
    end
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    launch(6, 1);
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (bus.inst !== model_mem[k]) begin
        n_fail++;
        $display("FAIL abort_slot_kept[%0d]: inst=%h, want %h", k, bus.inst, model_mem[k]);
      end
      tick();
    end
    n_checks++;
    if (bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_followup_done: done=%b, want 1", bus.done);
    end
    tick();
  endtask

  task automatic test_random();
    for (int r = 0; r < 10; r++) begin
      int len;
      int iter;
      for (int w = 0; w < 4; w++) load_slot($urandom_range(0, 15), {16'($urandom), $urandom});
      if (r % 4 == 3) begin
        len  = $urandom_range(0, 1) ? 0 : $urandom_range(17, 31);
        iter = $urandom_range(0, 3);
      end else begin
        len  = $urandom_range(1, 16);
        iter = $urandom_range(1, 3);
      end
      launch(len, iter);
      if (len >= 1 && len <= 16 && iter >= 1) begin
        for (int k = 0; k < len * iter; k++) begin
          n_checks++;
          if (bus.inst !== model_mem[k % len] || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL random_seq[%0d.%0d]: inst=%h busy=%b done=%b, want %h/1/0", r, k, bus.inst, bus.busy, bus.done, model_mem[k % len]);
          end
          tick();
        end
      end
      n_checks++;
      if (bus.inst !== 48'h0 || bus.done !== 1'b1 || bus.busy !== 1'b0) begin
        n_fail++;
        $display("FAIL random_end[%0d]: inst=%h done=%b busy=%b, want 0/1/0", r, bus.inst, bus.done, bus.busy);
      end
      tick();
    end
  endtask

`ifdef PE_CTX_STALL_EN
  task automatic test_stall();
    logic [47:0] exp_seq [7];
    load_slot(0, 48'h1);
    load_slot(1, 48'h2);
    exp_seq = '{48'h1, 48'h2, 48'h2, 48'h2, 48'h2, 48'h1, 48'h2};
    launch(2, 2);
    for (int k = 0; k < 7; k++) begin
      n_checks++;
      if (bus.inst !== exp_seq[k] || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_seq[%0d]: inst=%h busy=%b done=%b, want %h/1/0", k, bus.inst, bus.busy, bus.done, exp_seq[k]);
      end
      bus.stall = (k >= 1 && k <= 3);
      tick();
    end
    bus.stall = 1'b0;
    n_checks++;
    if (bus.inst !== 48'h0 || bus.done !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_end: inst=%h done=%b, want 0/1", bus.inst, bus.done);
    end
    tick();
  endtask
`endif

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst           = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.start     = 1'b0;
    bus.len       = '0;
    bus.iter_cnt  = '0;
    bus.abort     = 1'b0;
`ifdef PE_CTX_STALL_EN
    bus.stall     = 1'b0;
`endif
    for (int i = 0; i < 16; i++) model_mem[i] = 48'h0;
    test_reset();
    test_basic();
    test_invalid_start();
    test_bypass();
    test_abort();
    test_random();
`ifdef PE_CTX_STALL_EN
    test_stall();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
